fan_duty_sequencer: RTL and testbench

Sequences the fan-motor PWM duty for the multi-function fan. It arbitrates between the manual speed setting and a temperature-driven auto target. It gates the fan on operator presence from the ultrasonic range, applies a grace period when the operator leaves, and ramps duty one step at a time on start, stop and speed change. Its `duty` output feeds the fan `pwm_100` instance directly, replacing the combinational presence/timer gating in front of it.

---
 rtl/fan_duty_sequencer.sv | 155 +++++++++++++++
 tb/tb_fan_duty_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_duty_sequencer.sv
// Fan PWM duty sequencer: arbitrates manual/auto target, gates on operator presence
// with a grace period, and ramps duty one unit per step tick on start, stop and speed change.
module fan_duty_sequencer #(
   parameter int unsigned STEP_CYC  = 1_000_000,
   parameter int unsigned GRACE_CYC = 500_000_000,
   parameter int unsigned DIST_NEAR = 20,
   parameter int unsigned TEMP_LO   = 25,
   parameter int unsigned TEMP_HI   = 30
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mode_auto,
   input  logic [6:0]  manual_duty,
   input  logic [7:0]  temperature,
   input  logic [15:0] distance_cm,
   input  logic        timer_off,
   output logic [6:0]  duty,
   output logic        fan_on,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      StOff   = 3'd0,
      StRamp  = 3'd1,
      StRun   = 3'd2,
      StGrace = 3'd3,
      StStop  = 3'd4
   } state_e;

   localparam logic [31:0] StepLast  = 32'(STEP_CYC - 1);
   localparam logic [31:0] GraceLast = 32'(GRACE_CYC - 1);
   localparam logic [15:0] DistNear  = 16'(DIST_NEAR);
   localparam logic [7:0]  TempLo    = 8'(TEMP_LO);
   localparam logic [7:0]  TempHi    = 8'(TEMP_HI);

   state_e      state_q, state_d;
   logic [6:0]  duty_q, duty_d;
   logic        fan_on_q;
   logic [31:0] presc_q, presc_d;
   logic [31:0] grace_q, grace_d;

   logic [6:0]  auto_t;
   logic [6:0]  target;
   logic        present;
   logic        tick;

   always_comb begin
      if (temperature >= TempHi) begin
         auto_t = 7'd100;
      end else if (temperature >= TempLo) begin
         auto_t = 7'd50;
      end else begin
         auto_t = 7'd0;
      end
      if (timer_off) begin
         target = 7'd0;
      end else if (mode_auto) begin
         target = auto_t;
      end else begin
         target = (manual_duty > 7'd100) ? 7'd100 : manual_duty;
      end
   end

   assign present = (distance_cm < DistNear);
   assign tick    = (presc_q == StepLast);

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      unique case (state_q)
         StOff: begin
            duty_d = 7'd0;
            if (present && target != 7'd0) state_d = StRamp;
         end
         StRamp: begin
            if (tick) begin
               if (duty_q < target) begin
                  duty_d = duty_q + 7'd1;
               end else if (duty_q > target) begin
                  duty_d = duty_q - 7'd1;
               end
            end
            // Arrival is judged on the post-step duty so RUN and the final step coincide.
            if (target == 7'd0) begin
               state_d = StStop;
            end else if (!present) begin
               state_d = StGrace;
            end else if (duty_d == target) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (target == 7'd0) begin
               state_d = StStop;
            end else if (!present) begin
               state_d = StGrace;
            end else if (target != duty_q) begin
               state_d = StRamp;
            end
         end
         StGrace: begin
            if (target == 7'd0 || grace_q == GraceLast) begin
               state_d = StStop;
            end else if (present && duty_q == target) begin
               state_d = StRun;
            end else if (present) begin
               state_d = StRamp;
            end
         end
         StStop: begin
            if (tick && duty_q != 7'd0) duty_d = duty_q - 7'd1;
            if (duty_d == 7'd0) begin
               state_d = StOff;
            end else if (present && target != 7'd0) begin
               state_d = StRamp;
            end
         end
         default: begin
            state_d = StOff;
            duty_d  = 7'd0;
         end
      endcase
   end

   // Both counters restart on any state change so the first step lands STEP_CYC after entry.
   always_comb begin
      presc_d = 32'd0;
      grace_d = 32'd0;
      if (state_d == state_q) begin
         presc_d = tick ? 32'd0 : presc_q + 32'd1;
         grace_d = (state_q == StGrace) ? grace_q + 32'd1 : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StOff;
         duty_q   <= 7'd0;
         fan_on_q <= 1'b0;
         presc_q  <= 32'd0;
         grace_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         fan_on_q <= (duty_q != 7'd0);
         presc_q  <= presc_d;
         grace_q  <= grace_d;
      end
   end

   assign duty   = duty_q;
   assign fan_on = fan_on_q;
   assign state  = state_q;

endmodule

// File: tb/tb_fan_duty_sequencer.sv
// Directed bench for fan_duty_sequencer with STEP_CYC=4, GRACE_CYC=20; inputs driven and
// outputs sampled on the falling clock edge.
module tb_fan_duty_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mode_auto = 1'b0;
   logic [6:0]  manual_duty = 7'd3;
   logic [7:0]  temperature = 8'd22;
   logic [15:0] distance_cm = 16'd100;
   logic        timer_off = 1'b0;
   logic [6:0]  duty;
   logic        fan_on;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fan_duty_sequencer #(
      .STEP_CYC  (4),
      .GRACE_CYC (20),
      .DIST_NEAR (20),
      .TEMP_LO   (25),
      .TEMP_HI   (30)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode_auto   (mode_auto),
      .manual_duty (manual_duty),
      .temperature (temperature),
      .distance_cm (distance_cm),
      .timer_off   (timer_off),
      .duty        (duty),
      .fan_on      (fan_on),
      .state       (state)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         checks++;
         if ({state, duty, fan_on} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d state=%0d duty=%0d fan_on=%0b exp 0/0/0",
                     i, state, duty, fan_on);
         end
      end
      reset_n = 1'b1;
      cyc(2);
      checks++;
      if (state !== 3'd0 || duty !== 7'd0) begin
         errors++;
         $display("FAIL reset_release_absent state=%0d duty=%0d exp 0/0", state, duty);
      end
   endtask

   task automatic test_ramp_up();
      logic [6:0] exp_d;
      logic       exp_f;
      logic [2:0] exp_s;
      distance_cm = 16'd10;
      cyc(1);
      checks++;
      if (state !== 3'd1 || duty !== 7'd0) begin
         errors++;
         $display("FAIL ramp_entry state=%0d duty=%0d exp 1/0", state, duty);
      end
      for (int c = 1; c <= 12; c++) begin
         cyc(1);
         exp_d = 7'(c / 4);
         exp_f = ((c - 1) / 4) != 0;
         exp_s = (c < 12) ? 3'd1 : 3'd2;
         checks++;
         if (duty !== exp_d || fan_on !== exp_f || state !== exp_s) begin
            errors++;
            $display("FAIL ramp_up c=%0d duty=%0d fan_on=%0b state=%0d exp %0d/%0b/%0d",
                     c, duty, fan_on, state, exp_d, exp_f, exp_s);
         end
      end
   endtask

   task automatic test_grace();
      logic [6:0] exp_d;
      logic [2:0] exp_s;
      distance_cm = 16'd50;
      cyc(1);
      checks++;
      if (state !== 3'd3 || duty !== 7'd3) begin
         errors++;
         $display("FAIL grace_entry state=%0d duty=%0d exp 3/3", state, duty);
      end
      cyc(9);
      distance_cm = 16'd10;
      cyc(1);
      checks++;
      if (state !== 3'd2 || duty !== 7'd3) begin
         errors++;
         $display("FAIL grace_return state=%0d duty=%0d exp 2/3", state, duty);
      end
      distance_cm = 16'd50;
      cyc(1);
      checks++;
      if (state !== 3'd3) begin
         errors++;
         $display("FAIL grace_reentry state=%0d exp 3", state);
      end
      for (int k = 1; k < 20; k++) begin
         cyc(1);
         checks++;
         if (state !== 3'd3 || duty !== 7'd3) begin
            errors++;
            $display("FAIL grace_hold k=%0d state=%0d duty=%0d exp 3/3", k, state, duty);
         end
      end
      cyc(1);
      checks++;
      if (state !== 3'd4 || duty !== 7'd3) begin
         errors++;
         $display("FAIL grace_expire state=%0d duty=%0d exp 4/3", state, duty);
      end
      for (int s = 1; s <= 12; s++) begin
         cyc(1);
         exp_d = 7'(3 - s / 4);
         exp_s = (s < 12) ? 3'd4 : 3'd0;
         checks++;
         if (duty !== exp_d || state !== exp_s) begin
            errors++;
            $display("FAIL stop_ramp s=%0d duty=%0d state=%0d exp %0d/%0d",
                     s, duty, state, exp_d, exp_s);
         end
      end
      cyc(1);
      checks++;
      if (fan_on !== 1'b0) begin
         errors++;
         $display("FAIL stop_fan_off fan_on=%0b exp 0", fan_on);
      end
   endtask

   task automatic test_auto();
      mode_auto   = 1'b1;
      temperature = 8'd31;
      distance_cm = 16'd10;
      cyc(1);
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL auto_entry state=%0d exp 1", state);
      end
      cyc(20);
      checks++;
      if (duty !== 7'd5) begin
         errors++;
         $display("FAIL auto_duty5 duty=%0d exp 5", duty);
      end
      temperature = 8'd26;
      cyc(179);
      checks++;
      if (duty !== 7'd49 || state !== 3'd1) begin
         errors++;
         $display("FAIL auto_redirect duty=%0d state=%0d exp 49/1", duty, state);
      end
      cyc(1);
      checks++;
      if (duty !== 7'd50 || state !== 3'd2) begin
         errors++;
         $display("FAIL auto_arrive50 duty=%0d state=%0d exp 50/2", duty, state);
      end
      temperature = 8'd20;
      cyc(1);
      checks++;
      if (state !== 3'd4 || duty !== 7'd50) begin
         errors++;
         $display("FAIL auto_cold_stop state=%0d duty=%0d exp 4/50", state, duty);
      end
      cyc(4);
      checks++;
      if (duty !== 7'd49) begin
         errors++;
         $display("FAIL auto_first_down duty=%0d exp 49", duty);
      end
      cyc(196);
      checks++;
      if (duty !== 7'd0 || state !== 3'd0) begin
         errors++;
         $display("FAIL auto_stopped duty=%0d state=%0d exp 0/0", duty, state);
      end
   endtask

   task automatic test_saturation();
      logic [6:0] max_d;
      mode_auto   = 1'b0;
      manual_duty = 7'd120;
      cyc(1);
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL sat_entry state=%0d exp 1", state);
      end
      max_d = 7'd0;
      for (int i = 1; i <= 410; i++) begin
         cyc(1);
         if (duty > max_d) max_d = duty;
      end
      checks++;
      if (max_d !== 7'd100) begin
         errors++;
         $display("FAIL sat_max max_duty=%0d exp 100", max_d);
      end
      checks++;
      if (duty !== 7'd100 || state !== 3'd2) begin
         errors++;
         $display("FAIL sat_run duty=%0d state=%0d exp 100/2", duty, state);
      end
      timer_off   = 1'b1;
      distance_cm = 16'd50;
      cyc(1);
      checks++;
      if (state !== 3'd4 || duty !== 7'd100) begin
         errors++;
         $display("FAIL timer_off_stop state=%0d duty=%0d exp 4/100", state, duty);
      end
   endtask

   task automatic test_reramp();
      logic [6:0] exp_d;
      logic [2:0] exp_s;
      timer_off   = 1'b0;
      manual_duty = 7'd3;
      cyc(392);
      checks++;
      if (duty !== 7'd2 || state !== 3'd4) begin
         errors++;
         $display("FAIL reramp_stop duty=%0d state=%0d exp 2/4", duty, state);
      end
      distance_cm = 16'd10;
      cyc(1);
      checks++;
      if (state !== 3'd1 || duty !== 7'd2) begin
         errors++;
         $display("FAIL reramp_entry state=%0d duty=%0d exp 1/2", state, duty);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         exp_d = (i < 4) ? 7'd2 : 7'd3;
         exp_s = (i < 4) ? 3'd1 : 3'd2;
         checks++;
         if (duty !== exp_d || state !== exp_s) begin
            errors++;
            $display("FAIL reramp_up i=%0d duty=%0d state=%0d exp %0d/%0d",
                     i, duty, state, exp_d, exp_s);
         end
      end
   endtask

   task automatic test_async_reset();
      manual_duty = 7'd10;
      cyc(1);
      checks++;
      if (state !== 3'd1) begin
         errors++;
         $display("FAIL areset_ramp state=%0d exp 1", state);
      end
      cyc(4);
      checks++;
      if (duty !== 7'd4) begin
         errors++;
         $display("FAIL areset_pre duty=%0d exp 4", duty);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (duty !== 7'd0 || state !== 3'd0 || fan_on !== 1'b0) begin
         errors++;
         $display("FAIL areset_async duty=%0d state=%0d fan_on=%0b exp 0/0/0",
                  duty, state, fan_on);
      end
      distance_cm = 16'd100;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      checks++;
      if (duty !== 7'd0 || state !== 3'd0) begin
         errors++;
         $display("FAIL areset_after duty=%0d state=%0d exp 0/0", duty, state);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_grace();
      test_auto();
      test_saturation();
      test_reramp();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
